// File: rtl/step_profile_gen.sv
// step_profile_gen: trapezoidal step/direction pulse generator.
// Accepts a move command, emits one step pulse per motor step with a period
// that ramps from period_start down to period_min and back up near the end.
// An abort ramps down the same way and stops once the period reaches period_start.
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid && cmd_ready. cmd_ready is high only while the generator is idle.
// All cmd_* and profile inputs are sampled on that edge only.
module step_profile_gen #(
  parameter int W  = 28,
  parameter int CW = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_count,
  input  logic          cmd_dir,
  input  logic [W-1:0]  period_start,
  input  logic [W-1:0]  period_min,
  input  logic [W-1:0]  acc_step,
  input  logic [W-1:0]  dec_step,
  input  logic [CW-1:0] dec_start,
  input  logic          abort,
  output logic          step_out,
  output logic          dir_out,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [CW-1:0] pulses_done,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  // Period arithmetic runs one bit wider so sums and differences can be
  // range-checked before being narrowed back to W bits.
  localparam logic [W:0]   P_FLOOR_X = (W+1)'(2);
  localparam logic [W:0]   P_CEIL_X  = {1'b0, {W{1'b1}}};
  localparam logic [W-1:0] P_FLOOR   = W'(2);

  // Latched command and profile
  state_e        state_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  pstart_q;
  logic [W-1:0]  pmin_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  dec_q;
  logic [CW-1:0] dec_start_q;

  // Running move state
  logic [W-1:0]  period_q;
  logic [W-1:0]  timer_q;
  logic [CW-1:0] pulses_q;
  logic          abort_q;

  // Registered outputs
  logic          step_q;
  logic          dir_q;
  logic          busy_q;
  logic          done_q;
  logic          aborted_q;
  logic          ready_q;

  // Next-pulse decision terms
  logic          accept;
  logic [W-1:0]  start_p_d;
  logic [CW-1:0] rem_d;
  logic          abort_eff;
  logic          use_dec;
  logic [W:0]    dec_sum;
  logic [W:0]    dec_lim;
  logic [W:0]    acc_diff;
  logic [W:0]    acc_lim;
  logic [W-1:0]  period_d;
  logic          finish_norm;
  logic          finish_abort;

  // Narrow a widened period back to W bits, clamped to [2, 2^W-1].
  function automatic logic [W-1:0] clamp_p(input logic [W:0] v);
    logic [W-1:0] r;
    if (v < P_FLOOR_X) begin
      r = P_FLOOR;
    end else if (v > P_CEIL_X) begin
      r = {W{1'b1}};
    end else begin
      r = v[W-1:0];
    end
    return r;
  endfunction

  // Timer reload for the HIGH phase: (P>>1) cycles, counted down to zero.
  function automatic logic [W-1:0] high_m1(input logic [W-1:0] p);
    return (p >> 1) - W'(1);
  endfunction

  // Timer reload for the LOW phase: P - (P>>1) cycles, counted down to zero.
  function automatic logic [W-1:0] low_m1(input logic [W-1:0] p);
    return p - (p >> 1) - W'(1);
  endfunction

  // Handshake, start period and the period for the pulse after the current one.
  always_comb begin
    accept       = cmd_valid && ready_q;
    start_p_d    = (period_start < P_FLOOR) ? P_FLOOR : period_start;

    rem_d        = count_q - pulses_q;
    // An abort arriving on the final LOW cycle still counts for this decision.
    abort_eff    = abort_q | abort;
    use_dec      = abort_eff || (rem_d <= dec_start_q);
    finish_norm  = (rem_d == '0);
    finish_abort = abort_eff && (period_q >= pstart_q);

    // Deceleration: grow by dec_step, never beyond period_start.
    dec_sum = {1'b0, period_q} + {1'b0, dec_q};
    dec_lim = dec_sum;
    if (dec_sum > {1'b0, pstart_q}) begin
      dec_lim = {1'b0, pstart_q};
    end

    // Acceleration: shrink by acc_step, saturating at 2 on underflow,
    // then never below period_min.
    acc_diff = {1'b0, period_q} - {1'b0, acc_q};
    acc_lim  = acc_diff;
    if (acc_q > period_q) begin
      acc_lim = P_FLOOR_X;
    end
    if (acc_lim < {1'b0, pmin_q}) begin
      acc_lim = {1'b0, pmin_q};
    end

    if (use_dec) begin
      period_d = clamp_p(dec_lim);
    end else if (period_q > pmin_q) begin
      period_d = clamp_p(acc_lim);
    end else begin
      period_d = period_q;
    end
  end

  // Move sequencer: IDLE waits for a command, HIGH/LOW time each step pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      pstart_q    <= '0;
      pmin_q      <= '0;
      acc_q       <= '0;
      dec_q       <= '0;
      dec_start_q <= '0;
      period_q    <= '0;
      timer_q     <= '0;
      pulses_q    <= '0;
      abort_q     <= 1'b0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if ((state_q != S_IDLE) && abort) begin
        abort_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            count_q     <= cmd_count;
            pstart_q    <= period_start;
            pmin_q      <= period_min;
            acc_q       <= acc_step;
            dec_q       <= dec_step;
            dec_start_q <= dec_start;
            dir_q       <= cmd_dir;
            period_q    <= start_p_d;
            abort_q     <= 1'b0;
            aborted_q   <= 1'b0;
            if (cmd_count == '0) begin
              // Empty move: complete immediately without leaving IDLE.
              pulses_q <= '0;
              done_q   <= 1'b1;
            end else begin
              state_q  <= S_HIGH;
              timer_q  <= high_m1(start_p_d);
              pulses_q <= CW'(1);
              step_q   <= 1'b1;
              busy_q   <= 1'b1;
              ready_q  <= 1'b0;
            end
          end
        end

        S_HIGH: begin
          if (timer_q == '0) begin
            state_q <= S_LOW;
            step_q  <= 1'b0;
            timer_q <= low_m1(period_q);
          end else begin
            timer_q <= timer_q - W'(1);
          end
        end

        S_LOW: begin
          if (timer_q == '0) begin
            if (finish_norm || finish_abort) begin
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
              ready_q   <= 1'b1;
              done_q    <= 1'b1;
              aborted_q <= !finish_norm;
            end else begin
              // New period applies from this pulse onward, never mid-pulse.
              state_q  <= S_HIGH;
              period_q <= period_d;
              timer_q  <= high_m1(period_d);
              pulses_q <= pulses_q + CW'(1);
              step_q   <= 1'b1;
            end
          end else begin
            timer_q <= timer_q - W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          step_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = ready_q;
  assign step_out    = step_q;
  assign dir_out     = dir_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign pulses_done = pulses_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_step_profile_gen.sv
// tb_step_profile_gen: directed moves with hand-computed period sequences.
module tb_step_profile_gen;

  localparam int W  = 28;
  localparam int CW = 28;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_count = '0;
  logic          cmd_dir = 1'b0;
  logic [W-1:0]  period_start = '0;
  logic [W-1:0]  period_min = '0;
  logic [W-1:0]  acc_step = '0;
  logic [W-1:0]  dec_step = '0;
  logic [CW-1:0] dec_start = '0;
  logic          abort = 1'b0;
  logic          step_out;
  logic          dir_out;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [CW-1:0] pulses_done;
  logic [1:0]    dbg_state;

  step_profile_gen #(.W(W), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_count    (cmd_count),
    .cmd_dir      (cmd_dir),
    .period_start (period_start),
    .period_min   (period_min),
    .acc_step     (acc_step),
    .dec_step     (dec_step),
    .dec_start    (dec_start),
    .abort        (abort),
    .step_out     (step_out),
    .dir_out      (dir_out),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .pulses_done  (pulses_done),
    .dbg_state    (dbg_state)
  );

  // Scoreboard: expected periods per pulse, observed high/low run lengths
  logic [W-1:0] exp_q[$];
  int obs_h[$];
  int obs_l[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Offer one command, hold it for the accepting edge, then scramble the fields.
  task automatic send_cmd(input logic [CW-1:0] cnt, input logic d,
                          input logic [W-1:0] ps, input logic [W-1:0] pm,
                          input logic [W-1:0] as, input logic [W-1:0] ds,
                          input logic [CW-1:0] dst);
    @(negedge clk);
    check_eq("ready_before_cmd", cmd_ready, 1);
    cmd_count    = cnt;
    cmd_dir      = d;
    period_start = ps;
    period_min   = pm;
    acc_step     = as;
    dec_step     = ds;
    dec_start    = dst;
    cmd_valid    = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
    cmd_count    = CW'($urandom);
    cmd_dir      = ~d;
    period_start = W'($urandom);
    period_min   = W'($urandom);
    acc_step     = W'($urandom);
    dec_step     = W'($urandom);
    dec_start    = CW'($urandom);
  endtask

  // Sample each cycle after accept until done; record per-pulse high/low lengths.
  task automatic watch_move(input int abort_pulse, input int budget,
                            output int total, output bit timeout, output bit any_busy);
    int h;
    int l;
    int pulses;
    bit prev;
    obs_h.delete();
    obs_l.delete();
    h = 0; l = 0; pulses = 0; prev = 1'b0;
    total = 0; timeout = 1'b1; any_busy = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      abort = 1'b0;
      any_busy = any_busy | busy;
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (step_out && !prev) begin
        if (pulses > 0) begin
          obs_h.push_back(h);
          obs_l.push_back(l);
        end
        pulses++;
        h = 0; l = 0;
        if (pulses == abort_pulse) abort = 1'b1;
      end
      if (step_out) h++; else l++;
      prev = step_out;
      total++;
    end
    if (pulses > 0) begin
      obs_h.push_back(h);
      obs_l.push_back(l);
    end
  endtask

  // Compare observed pulses against exp_q and the total move length.
  task automatic check_move(input string tag, input int total_exp,
                            input int total, input bit timeout);
    logic [W-1:0] p;
    int eh;
    int el;
    check_eq({tag, "_timeout"}, timeout, 0);
    check_eq({tag, "_npulses"}, obs_h.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_h.size(); i++) begin
      p  = exp_q[i];
      eh = int'(p >> 1);
      el = int'(p) - eh;
      check_eq($sformatf("%s_high%0d", tag, i), obs_h[i], eh);
      check_eq($sformatf("%s_low%0d", tag, i), obs_l[i], el);
    end
    check_eq({tag, "_total"}, total, total_exp);
    check_eq({tag, "_busy_at_done"}, busy, 0);
    check_eq({tag, "_ready_at_done"}, cmd_ready, 1);
  endtask

  initial begin
    int  total;
    bit  tmo;
    bit  any_b;

    repeat (3) @(negedge clk);
    check_eq("rst_step", step_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_step", step_out, 0);
    check_eq("idle_dir", dir_out, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_done", done, 0);
    check_eq("idle_aborted", aborted, 0);
    check_eq("idle_pulses", pulses_done, 0);
    check_eq("idle_ready", cmd_ready, 1);
    check_eq("idle_state", dbg_state, 0);

    // Constant period 10: three 5/5 pulses, 30 cycles
    send_cmd(3, 1'b1, 10, 10, 0, 0, 0);
    check_eq("t1_first_step", step_out, 1);
    check_eq("t1_dir", dir_out, 1);
    watch_move(0, 200, total, tmo, any_b);
    exp_q.delete();
    repeat (3) exp_q.push_back(10);
    check_move("t1", 30, total, tmo);
    check_eq("t1_pulses", pulses_done, 3);
    check_eq("t1_aborted", aborted, 0);

    // Trapezoid: 20,16,12,8,8,12,16,20 = 112 cycles
    send_cmd(8, 1'b0, 20, 8, 4, 4, 3);
    watch_move(0, 400, total, tmo, any_b);
    exp_q.delete();
    exp_q.push_back(20); exp_q.push_back(16); exp_q.push_back(12); exp_q.push_back(8);
    exp_q.push_back(8);  exp_q.push_back(12); exp_q.push_back(16); exp_q.push_back(20);
    check_move("t2", 112, total, tmo);
    check_eq("t2_pulses", pulses_done, 8);
    check_eq("t2_dir", dir_out, 0);

    // Abort during pulse 10: ramp 12,16,20 after it, 13 pulses, 152 cycles
    send_cmd(100, 1'b1, 20, 8, 4, 4, 3);
    watch_move(10, 600, total, tmo, any_b);
    exp_q.delete();
    exp_q.push_back(20); exp_q.push_back(16); exp_q.push_back(12);
    repeat (7) exp_q.push_back(8);
    exp_q.push_back(12); exp_q.push_back(16); exp_q.push_back(20);
    check_move("t3", 152, total, tmo);
    check_eq("t3_pulses", pulses_done, 13);
    check_eq("t3_aborted", aborted, 1);

    // Empty move: done next cycle, no step, never busy, aborted cleared
    send_cmd(0, 1'b0, 10, 10, 0, 0, 0);
    watch_move(0, 10, total, tmo, any_b);
    exp_q.delete();
    check_move("t4", 0, total, tmo);
    check_eq("t4_busy_seen", any_b, 0);
    check_eq("t4_aborted", aborted, 0);
    check_eq("t4_pulses", pulses_done, 0);
    @(negedge clk);
    check_eq("t4_done_one_cycle", done, 0);

    // Odd period 7: high 3, low 4
    send_cmd(1, 1'b0, 7, 7, 0, 0, 0);
    watch_move(0, 50, total, tmo, any_b);
    exp_q.delete();
    exp_q.push_back(7);
    check_move("t5", 7, total, tmo);

    // Start period 1 clamps to 2
    send_cmd(2, 1'b0, 1, 0, 0, 0, 0);
    watch_move(0, 50, total, tmo, any_b);
    exp_q.delete();
    exp_q.push_back(2); exp_q.push_back(2);
    check_move("t6", 4, total, tmo);

    // acc_step larger than period saturates to 2
    send_cmd(2, 1'b0, 20, 0, 50, 0, 0);
    watch_move(0, 100, total, tmo, any_b);
    exp_q.delete();
    exp_q.push_back(20); exp_q.push_back(2);
    check_move("t7", 22, total, tmo);

    // period_min above period_start: cruise at period_start
    send_cmd(3, 1'b0, 10, 30, 4, 4, 1);
    watch_move(0, 100, total, tmo, any_b);
    exp_q.delete();
    repeat (3) exp_q.push_back(10);
    check_move("t8", 30, total, tmo);

    // Reset mid-HIGH drops everything at once, then a new move runs
    send_cmd(5, 1'b1, 10, 10, 0, 0, 0);
    @(negedge clk);
    check_eq("t9_high_before_rst", step_out, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t9_rst_step", step_out, 0);
    check_eq("t9_rst_busy", busy, 0);
    check_eq("t9_rst_pulses", pulses_done, 0);
    check_eq("t9_rst_dir", dir_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("t9_ready_after_rst", cmd_ready, 1);
    send_cmd(2, 1'b1, 10, 10, 0, 0, 0);
    watch_move(0, 100, total, tmo, any_b);
    exp_q.delete();
    exp_q.push_back(10); exp_q.push_back(10);
    check_move("t9", 20, total, tmo);
    check_eq("t9_pulses", pulses_done, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
